// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the ALU sequencing controller.
package alu_seq_pkg;

    localparam int DEFAULT_W = 4;

    typedef enum logic [1:0] {
        LIVE    = 2'd0,
        LATCH   = 2'd1,
        CAPTURE = 2'd2,
        SHOW    = 2'd3
    } seq_state_e;

    // LATCH and CAPTURE are the only states in which the ALU is being sequenced
    function automatic logic state_is_busy(input seq_state_e s);
        return (s == LATCH) || (s == CAPTURE);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Operand/result bus between the sequencing controller (master) and the ALU (slave).
interface alu_seq_ctrl_if
    import alu_seq_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2*W-1:0] alu_result;
    logic           alu_cf;
    logic           alu_of;

    modport master (
        output alu_a,
        output alu_b,
        input  alu_result,
        input  alu_cf,
        input  alu_of
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        output alu_result,
        output alu_cf,
        output alu_of
    );
endinterface

// File: rtl/button_debounce.sv
// Button conditioner: 2-FF synchronizer, optional debounce filter (ALU_SEQ_DEBOUNCE_EN)
// and rising-edge detect producing a one-cycle press pulse.
module button_debounce
    import alu_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    logic sync1_r;
    logic sync2_r;
    logic level_s;
    logic level_d_r;

    // Bring the asynchronous button level into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic          level_r;

    // Accept a new level only after it has disagreed with the current one long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CW{1'b0}};
            level_r <= 1'b0;
        end else if (sync2_r == level_r) begin
            cnt_r   <= {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= {CW{1'b0}};
            level_r <= sync2_r;
        end else begin
            cnt_r   <= cnt_r + CW'(1);
        end
    end

    assign level_s = level_r;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign level_s = sync2_r;
`endif

    // Previous accepted level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_s;
        end
    end

    // Pulse is formed from registered levels only, so it is glitch-free
    assign press = level_s & ~level_d_r;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the adder/display datapath. Optional debounce filter
// is enabled with ALU_SEQ_DEBOUNCE_EN; without it buttons are only synchronized.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int W               = DEFAULT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Button_left,
    input  logic                  Button_right,
    input  logic [W-1:0]          Data1,
    input  logic [W-1:0]          Data2,
    alu_seq_ctrl_if.master        alu,
    output logic [2*W-1:0]        disp_data,
    output logic                  disp_is_result,
    output logic                  CF,
    output logic                  OF,
    output logic                  busy
);

    seq_state_e   state_r;
    logic [W-1:0] alu_a_r;
    logic [W-1:0] alu_b_r;
    logic         press_left_s;
    logic         press_right_s;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_left (
        .clk   (CLK),
        .rst   (RST),
        .raw   (Button_left),
        .press (press_left_s)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_right (
        .clk   (CLK),
        .rst   (RST),
        .raw   (Button_right),
        .press (press_right_s)
    );

    assign alu.alu_a = alu_a_r;
    assign alu.alu_b = alu_b_r;

    // Sequencer: state, operand latches, captured flags and display registers.
    // Presses arriving in LATCH/CAPTURE are dropped; in SHOW left beats right.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r        <= LIVE;
            alu_a_r        <= {W{1'b0}};
            alu_b_r        <= {W{1'b0}};
            disp_data      <= {(2*W){1'b0}};
            disp_is_result <= 1'b0;
            CF             <= 1'b0;
            OF             <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state_r)
                LIVE: begin
                    disp_data      <= {Data1, Data2};
                    disp_is_result <= 1'b0;
                    if (press_right_s) begin
                        state_r <= LATCH;
                        alu_a_r <= Data1;
                        alu_b_r <= Data2;
                        busy    <= state_is_busy(LATCH);
                    end else begin
                        state_r <= LIVE;
                        busy    <= 1'b0;
                    end
                end
                LATCH: begin
                    // One cycle for the ALU to settle on the new operands
                    state_r <= CAPTURE;
                    busy    <= state_is_busy(CAPTURE);
                end
                CAPTURE: begin
                    CF             <= alu.alu_cf;
                    OF             <= alu.alu_of;
                    disp_data      <= alu.alu_result;
                    disp_is_result <= 1'b1;
                    busy           <= state_is_busy(SHOW);
                    state_r        <= SHOW;
                end
                SHOW: begin
                    if (press_left_s) begin
                        state_r        <= LIVE;
                        disp_is_result <= 1'b0;
                        busy           <= 1'b0;
                    end else if (press_right_s) begin
                        state_r        <= LATCH;
                        alu_a_r        <= Data1;
                        alu_b_r        <= Data2;
                        disp_is_result <= 1'b0;
                        busy           <= state_is_busy(LATCH);
                    end else begin
                        state_r        <= SHOW;
                        disp_is_result <= 1'b1;
                        busy           <= 1'b0;
                    end
                end
                default: begin
                    state_r        <= LIVE;
                    disp_is_result <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed scoreboard bench for alu_seq_ctrl; adapts press latency to ALU_SEQ_DEBOUNCE_EN.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int W = 4;
    localparam int D = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int LAT = 2 + D;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [2*W-1:0] result;
        logic           cf;
        logic           of;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           btn_l;
    logic           btn_r;
    logic [W-1:0]   data1;
    logic [W-1:0]   data2;
    logic [2*W-1:0] disp_data;
    logic           disp_is_result;
    logic           cf;
    logic           of;
    logic           busy;

    exp_t sb[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   n_compute = 0;
    int   c0;
    logic busy_d    = 1'b0;

    alu_seq_ctrl_if #(.W(W)) alu_bus ();

    alu_seq_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .W               (W)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .Button_left    (btn_l),
        .Button_right   (btn_r),
        .Data1          (data1),
        .Data2          (data2),
        .alu            (alu_bus),
        .disp_data      (disp_data),
        .disp_is_result (disp_is_result),
        .CF             (cf),
        .OF             (of),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Bench ALU: integer add, carry when the sum leaves W bits, overflow out of signed range
    int sum_u;
    int sum_s;
    assign sum_u = int'(alu_bus.alu_a) + int'(alu_bus.alu_b);
    assign sum_s = int'($signed(alu_bus.alu_a)) + int'($signed(alu_bus.alu_b));
    assign alu_bus.alu_result = (2*W)'(sum_u);
    assign alu_bus.alu_cf     = (sum_u >= (1 << W));
    assign alu_bus.alu_of     = (sum_s > ((1 << (W-1)) - 1)) || (sum_s < -(1 << (W-1)));

    // Count compute sequences by rising edges of busy
    always @(negedge clk) begin
        busy_d <= busy;
        if (busy && !busy_d) n_compute <= n_compute + 1;
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        exp_t e;
        s        = {1'b0, a} + {1'b0, b};
        e.result = {{(W-1){1'b0}}, s};
        e.cf     = s[W];
        e.of     = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        check({tag, "_state_show"}, 32'(dut.state_r), 32'(SHOW));
        check({tag, "_disp"},       32'(disp_data),   32'(e.result));
        check({tag, "_cf"},         32'(cf),          32'(e.cf));
        check({tag, "_of"},         32'(of),          32'(e.of));
        check({tag, "_is_result"},  32'(disp_is_result), 32'd1);
        check({tag, "_busy_done"},  32'(busy),        32'd0);
    endtask

    // Right press and the LATCH/CAPTURE/SHOW timeline that follows its pulse
    task automatic compute(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold);
        int start;
        start = n_compute;
        data1 = a;
        data2 = b;
        sb.push_back(model(a, b));
        btn_r = 1'b1;
        cyc(LAT + 1);
        @(negedge clk);
        check({tag, "_latch"},  32'(dut.state_r),   32'(LATCH));
        check({tag, "_alu_a"},  32'(alu_bus.alu_a), 32'(a));
        check({tag, "_alu_b"},  32'(alu_bus.alu_b), 32'(b));
        check({tag, "_busy1"},  32'(busy),          32'd1);
        cyc(1);
        @(negedge clk);
        check({tag, "_capture"}, 32'(dut.state_r), 32'(CAPTURE));
        check({tag, "_busy2"},   32'(busy),        32'd1);
        cyc(1);
        @(negedge clk);
        check_result(tag);
        if (hold > LAT + 3) cyc(hold - (LAT + 3));
        btn_r = 1'b0;
        cyc(LAT + 2);
        check({tag, "_held_show"}, 32'(dut.state_r), 32'(SHOW));
        check({tag, "_one_compute"}, 32'(n_compute), 32'(start + 1));
    endtask

    task automatic press_left(input string tag);
        btn_l = 1'b1;
        cyc(LAT + 1);
        @(negedge clk);
        check({tag, "_live"},      32'(dut.state_r),   32'(LIVE));
        check({tag, "_not_result"}, 32'(disp_is_result), 32'd0);
        btn_l = 1'b0;
        cyc(LAT + 2);
    endtask

    initial begin
        rst   = 1'b1;
        btn_l = 1'b0;
        btn_r = 1'b0;
        data1 = 4'd3;
        data2 = 4'd5;

        // Reset state while switches are non-zero
        cyc(3);
        @(negedge clk);
        check("rst_disp",   32'(disp_data),      32'd0);
        check("rst_isres",  32'(disp_is_result), 32'd0);
        check("rst_cf",     32'(cf),             32'd0);
        check("rst_of",     32'(of),             32'd0);
        check("rst_busy",   32'(busy),           32'd0);
        check("rst_alu_a",  32'(alu_bus.alu_a),  32'd0);
        check("rst_alu_b",  32'(alu_bus.alu_b),  32'd0);
        check("rst_state",  32'(dut.state_r),    32'(LIVE));
        rst = 1'b0;
        cyc(1);
        @(negedge clk);
        check("live_35", 32'(disp_data), 32'h35);

        // Live view lags the switches by one cycle
        cyc(1);
        data1 = 4'hA;
        data2 = 4'h6;
        @(negedge clk);
        check("live_lag_old", 32'(disp_data), 32'h35);
        cyc(1);
        @(negedge clk);
        check("live_lag_new", 32'(disp_data), 32'hA6);

        compute("compute", 4'd9, 4'd8, 10);
        compute("recompute", 4'd1, 4'd1, 0);
        press_left("left_back");
        check("live_11",     32'(disp_data), 32'h11);
        check("live_cf_keep", 32'(cf),       32'd0);
        check("live_of_keep", 32'(of),       32'd0);

`ifdef ALU_SEQ_DEBOUNCE_EN
        // Bounce shorter than the filter window
        c0 = n_compute;
        for (int i = 0; i < 10; i++) begin
            btn_r = ~btn_r;
            cyc(2);
        end
        btn_r = 1'b0;
        cyc(LAT + 4);
        check("bounce_state",   32'(dut.state_r), 32'(LIVE));
        check("bounce_compute", 32'(n_compute),   32'(c0));
`endif

        // Both buttons together in SHOW: left wins, no recompute
        compute("prio_setup", 4'd9, 4'd8, 0);
        c0    = n_compute;
        data1 = 4'd2;
        data2 = 4'd3;
        btn_l = 1'b1;
        btn_r = 1'b1;
        cyc(LAT + 1);
        @(negedge clk);
        check("prio_live", 32'(dut.state_r), 32'(LIVE));
        btn_l = 1'b0;
        btn_r = 1'b0;
        cyc(LAT + 2);
        check("prio_no_compute", 32'(n_compute),     32'(c0));
        check("prio_alu_a_kept", 32'(alu_bus.alu_a), 32'd9);
        check("prio_cf_hold",    32'(cf),            32'd1);
        check("prio_of_hold",    32'(of),            32'd1);

        // Left press landing in LATCH is dropped
        c0    = n_compute;
        data1 = 4'd7;
        data2 = 4'd7;
        sb.push_back(model(4'd7, 4'd7));
        btn_r = 1'b1;
        cyc(1);
        btn_l = 1'b1;
        cyc(LAT);
        @(negedge clk);
        check("drop_l_latch", 32'(dut.state_r), 32'(LATCH));
        cyc(2);
        @(negedge clk);
        check_result("drop_l");
        cyc(2);
        @(negedge clk);
        check("drop_l_stay_show", 32'(dut.state_r), 32'(SHOW));
        btn_l = 1'b0;
        btn_r = 1'b0;
        cyc(LAT + 2);
        check("drop_l_show",    32'(dut.state_r), 32'(SHOW));
        check("drop_l_compute", 32'(n_compute),   32'(c0 + 1));

`ifndef ALU_SEQ_DEBOUNCE_EN
        // Single-cycle pulses: second right press lands in CAPTURE and is dropped
        c0    = n_compute;
        data1 = 4'd1;
        data2 = 4'd2;
        sb.push_back(model(4'd1, 4'd2));
        btn_r = 1'b1;
        cyc(1);
        btn_r = 1'b0;
        cyc(1);
        btn_r = 1'b1;
        cyc(1);
        btn_r = 1'b0;
        @(negedge clk);
        check("raw3_latch", 32'(dut.state_r), 32'(LATCH));
        cyc(1);
        @(negedge clk);
        check("raw3_capture", 32'(dut.state_r), 32'(CAPTURE));
        cyc(1);
        @(negedge clk);
        check_result("drop_r");
        cyc(3);
        check("drop_r_show",    32'(dut.state_r), 32'(SHOW));
        check("drop_r_compute", 32'(n_compute),   32'(c0 + 1));
`endif

        // Reset during CAPTURE; the capture edge would otherwise set CF/OF
        data1 = 4'd9;
        data2 = 4'd8;
        btn_r = 1'b1;
        cyc(LAT + 2);
        @(negedge clk);
        check("rstcap_capture", 32'(dut.state_r), 32'(CAPTURE));
        rst   = 1'b1;
        btn_r = 1'b0;
        cyc(1);
        @(negedge clk);
        check("rstcap_live",  32'(dut.state_r),      32'(LIVE));
        check("rstcap_cf",    32'(cf),               32'd0);
        check("rstcap_of",    32'(of),               32'd0);
        check("rstcap_busy",  32'(busy),             32'd0);
        check("rstcap_isres", 32'(disp_is_result),   32'd0);
        check("rstcap_disp",  32'(disp_data),        32'd0);
        sb.delete();
        rst = 1'b0;
        cyc(LAT + 3);
        @(negedge clk);
        check("rstcap_stay_live", 32'(dut.state_r), 32'(LIVE));
        check("rstcap_idle",      32'(busy),        32'd0);
        check("rstcap_live_view", 32'(disp_data),   32'h98);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencing controller for the four-bit adder/display datapath. It debounces the two raw push-buttons, latches the switch operands into the ALU on demand and registers the ALU result and flags once the ALU has settled. It also drives the display mux select and display data, so the board shows live operands or a frozen result. It sits between the board I/O and the existing ALU/Display instances in the top level.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a button level change is accepted; minimum 1.
- W, 4: operand width; result width is 2*W.
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- Button_left  in  1  raw button; requests the live-operand view.
- Button_right  in  1  raw button; requests a compute and the result view.
- Data1  in  W  switch operand A.
- Data2  in  W  switch operand B.
- alu_a  out  W  latched operand A to ALU.
- alu_b  out  W  latched operand B to ALU.
- alu_result  in  2W  ALU result.
- alu_cf  in  1  ALU carry flag.
- alu_of  in  1  ALU overflow flag.
- disp_data  out  2W  value to display.
- disp_is_result  out  1  high while the result is shown.
- CF  out  1  registered carry of the last compute.
- OF  out  1  registered overflow of the last compute.
- busy  out  1  high in LATCH and CAPTURE.

## Operation
- Each button passes through a 2-FF synchronizer and then the debounce filter. Filter: counter clears while the synced level equals the accepted level. Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears. A rising edge of the accepted level produces a one-cycle press pulse.
- FSM states: LIVE, LATCH, CAPTURE, SHOW. Reset state is LIVE.
- LIVE: disp_data <= {Data1,Data2} every cycle. disp_is_result=0. A right press goes to LATCH and loads alu_a<=Data1, alu_b<=Data2.
- LATCH: one settle cycle, then unconditionally CAPTURE.
- CAPTURE: registers CF<=alu_cf, OF<=alu_of and disp_data<=alu_result, then goes to SHOW.
- SHOW: disp_is_result=1 and disp_data is held. A left press goes to LIVE. A right press goes to LATCH with fresh operands.
- Presses in LATCH or CAPTURE are dropped, not queued.
- If both presses arrive in the same cycle in SHOW, left wins.
- A left press in LIVE is a no-op.
- CF and OF hold their values across LIVE until the next CAPTURE.
- alu_a and alu_b change only on entry to LATCH.
- Reset values: alu_a=0, alu_b=0, disp_data=0, disp_is_result=0, CF=0, OF=0, busy=0. Debounce counters are 0, accepted levels are 0, synchronizers are 0.
- RST asserted mid-sequence forces LIVE on the next edge. A pending press is discarded.

## Timing
- Raw press to press pulse: 2 sync cycles plus DEBOUNCE_CYCLES cycles.
- Press pulse in cycle t: state=LATCH and alu_a/alu_b valid at t+1; CAPTURE at t+2; SHOW with disp_is_result=1 and valid CF/OF at t+3. busy is high for cycles t+1 and t+2.
- LIVE display lags the switches by one cycle.
- A button held for any duration produces exactly one pulse. Release produces no pulse.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never wraps.

## Configuration
- ALU_SEQ_DEBOUNCE_EN defined: debounce filter as described above.
- ALU_SEQ_DEBOUNCE_EN undefined: the filter is removed and the accepted level is the synchronizer output directly. Press-to-pulse latency is 2 cycles and DEBOUNCE_CYCLES is ignored. All FSM behaviour is unchanged.

## Structure
- Package alu_seq_pkg holds the state enum (LIVE, LATCH, CAPTURE, SHOW) and the default W constant.
- One sub-module, button_debounce, contains the synchronizer, the filter and the edge detect. It is instantiated twice. It honours ALU_SEQ_DEBOUNCE_EN.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4 and the macro defined unless noted.
- Reset: RST high 3 cycles → all outputs 0, state LIVE; Data1=3, Data2=5 → disp_data=0x35 one cycle later.
- Compute: Data1=9, Data2=8, ALU model adds with CF/OF; right held 10 cycles → one pulse; alu_a=9, alu_b=8 at t+1; busy high for 2 cycles; at t+3 disp_data=0x11, CF=1, OF=1, disp_is_result=1.
- Bounce: right toggled high/low every 2 cycles for 20 cycles, then low → no pulse; state stays LIVE.
- Priority: in SHOW, left and right both pressed with edges aligned → state LIVE and no recompute. Right pressed again during busy → ignored, and exactly one compute occurs.
- Recompute and return: in SHOW, change Data1=1, Data2=1 and press right → disp_data=0x02, CF=0, OF=0. Press left → live view 0x11, and CF/OF still 0.
- Macro undefined: a single-cycle right pulse → LATCH exactly 3 cycles after the raw edge. RST asserted in CAPTURE → LIVE on the next edge, with CF/OF=0.
